// File: rtl/trigger_capture.sv
// Trigger capture stage: circular sample buffer with level/forced trigger and
// a pre/post-trigger window streamed out over valid/ready, oldest sample first.
module trigger_capture #(
  parameter int pAddrWidth = 9,
  parameter int pPreTrig   = 128
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iData,
  input  logic       iData_Valid,
  input  logic       iArm,
  input  logic       iForce,
  input  logic [7:0] iTrigLevel,
  input  logic       iTrigRising,
  output logic [7:0] oData,
  output logic       oData_Valid,
  input  logic       iData_Ready,
  output logic       oBusy,
  output logic       oTriggered,
  output logic       oDone,
  output logic [2:0] oDbgState
);

  localparam int lpDepth = 1 << pAddrWidth;
  localparam logic [pAddrWidth:0] lpDepthC = (pAddrWidth + 1)'(lpDepth);
  localparam logic [pAddrWidth:0] lpPreM1  = (pAddrWidth + 1)'(pPreTrig - 1);
  localparam logic [pAddrWidth:0] lpPost   = (pAddrWidth + 1)'(lpDepth - pPreTrig - 1);
  localparam logic [pAddrWidth:0] lpLast   = (pAddrWidth + 1)'(lpDepth - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [pAddrWidth-1:0] r_wr;
  logic [pAddrWidth-1:0] r_rd;
  logic [pAddrWidth:0]   r_fill_cnt;
  logic [pAddrWidth:0]   r_post_cnt;
  logic [pAddrWidth:0]   r_issue_cnt;
  logic [pAddrWidth:0]   r_xfer_cnt;
  logic [7:0]            r_prev;
  logic                  r_force_pend;
  logic                  r_trig;
  logic                  r_done;
  logic                  r_mid_valid;
  logic                  r_out_valid;
  logic [7:0]            r_out_data;
  logic [7:0]            r_ram_q;
  logic [7:0]            r_mem [0:lpDepth-1];

  logic w_wr_en;
  logic w_level_hit;
  logic w_trig;
  logic w_fill_last;
  logic w_post_last;
  logic w_xfer;
  logic w_out_take;
  logic w_rd_en;
  logic w_last_xfer;

  // Readout handshake: a sample moves when oData_Valid && iData_Ready; while
  // valid is high and ready low, oData/oData_Valid hold. r_ram_q is a one-deep
  // prefetch stage in front of the output register.
  always_comb begin
    w_wr_en     = iData_Valid && ((r_state == S_FILL) || (r_state == S_ARMED) ||
                                  (r_state == S_POST));
    w_level_hit = iTrigRising ? ((r_prev < iTrigLevel) && (iData >= iTrigLevel))
                              : ((r_prev >= iTrigLevel) && (iData < iTrigLevel));
    w_trig      = (r_state == S_ARMED) && iData_Valid && (w_level_hit || r_force_pend);
    w_fill_last = (r_state == S_FILL) && iData_Valid && (r_fill_cnt == lpPreM1);
    w_post_last = (r_state == S_POST) && iData_Valid && (r_post_cnt == 1);
    w_xfer      = r_out_valid && iData_Ready;
    w_out_take  = !r_out_valid || iData_Ready;
    w_rd_en     = (r_state == S_READOUT) && (r_issue_cnt != lpDepthC) &&
                  (!r_mid_valid || w_out_take);
    w_last_xfer = (r_state == S_READOUT) && w_xfer && (r_xfer_cnt == lpLast);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (iArm) w_next = S_FILL;
      S_FILL:    if (w_fill_last) w_next = S_ARMED;
      S_ARMED:   if (w_trig) w_next = (lpPost == '0) ? S_READOUT : S_POST;
      S_POST:    if (w_post_last) w_next = S_READOUT;
      S_READOUT: if (w_last_xfer) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state      <= S_IDLE;
      r_wr         <= '0;
      r_rd         <= '0;
      r_fill_cnt   <= '0;
      r_post_cnt   <= '0;
      r_issue_cnt  <= '0;
      r_xfer_cnt   <= '0;
      r_prev       <= '0;
      r_force_pend <= 1'b0;
      r_trig       <= 1'b0;
      r_done       <= 1'b0;
      r_mid_valid  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (w_wr_en) begin
        r_wr   <= r_wr + 1'b1;
        r_prev <= iData;
      end
      case (r_state)
        S_IDLE: begin
          if (iArm) begin
            r_wr       <= '0;
            r_fill_cnt <= '0;
          end
        end
        S_FILL: begin
          if (iData_Valid) r_fill_cnt <= r_fill_cnt + 1'b1;
        end
        S_ARMED: begin
          if (iForce) r_force_pend <= 1'b1;
          if (w_trig) begin
            // r_wr + 1 is the slot after the trigger sample, i.e. the oldest
            // sample once the post-trigger samples have wrapped around.
            r_trig       <= 1'b1;
            r_force_pend <= 1'b0;
            r_post_cnt   <= lpPost;
            r_rd         <= r_wr + 1'b1;
            r_issue_cnt  <= '0;
            r_xfer_cnt   <= '0;
          end
        end
        S_POST: begin
          if (iData_Valid) r_post_cnt <= r_post_cnt - 1'b1;
          if (w_post_last) begin
            r_rd        <= r_wr + 1'b1;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
          end
        end
        S_READOUT: begin
          if (w_rd_en) begin
            r_rd        <= r_rd + 1'b1;
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (w_rd_en) r_mid_valid <= 1'b1;
          else if (w_out_take) r_mid_valid <= 1'b0;
          if (w_out_take) begin
            r_out_valid <= r_mid_valid;
            if (r_mid_valid) r_out_data <= r_ram_q;
          end
          if (w_xfer) r_xfer_cnt <= r_xfer_cnt + 1'b1;
          if (w_last_xfer) begin
            r_done      <= 1'b1;
            r_trig      <= 1'b0;
            r_out_valid <= 1'b0;
            r_mid_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer RAM: no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge iClk) begin
    if (w_wr_en) r_mem[r_wr] <= iData;
    if (w_rd_en) r_ram_q <= r_mem[r_rd];
  end

  assign oData       = r_out_data;
  assign oData_Valid = r_out_valid;
  assign oBusy       = (r_state != S_IDLE);
  assign oTriggered  = r_trig;
  assign oDone       = r_done;
  assign oDbgState   = r_state;

endmodule
